screen_ram_arbiter: RTL
=======================

Name: screen_ram_arbiter

Overview:
Shares one single-port 8K x 16 screen RAM between two requesters: the CPU data path (screen window 0x4000–0x5FFF) and the frame_buffer pixel fetch. The display has fixed priority, and an anti-starvation counter bounds CPU wait. The arbiter registers the RAM command and tags each read so returning data is routed to its issuer. It sits between cpu/memory and frame_buffer inside computer, clocked by CLOCK_50.

Parameters:
ADDR_W, 13, screen word address width
DATA_W, 16, word width
RAM_LAT, 1, cycles from registered RAM command to valid ram_rdata (1..3)
MAX_WAIT, 8, consecutive denied CPU cycles before CPU wins a conflict (1..255)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset  in  1  synchronous, active-high
cpu_req  in  1  CPU access request; held with payload until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  request accepted this cycle (combinational)
cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse
cpu_rdata  out  DATA_W  CPU read data
disp_req  in  1  display read request (read-only port)
disp_addr  in  ADDR_W  display word address
disp_ack  out  1  display request accepted this cycle (combinational)
disp_rvalid  out  1  disp_rdata valid, one-cycle pulse
disp_rdata  out  DATA_W  display read data
ram_addr  out  ADDR_W  registered RAM address
ram_we  out  1  registered RAM write enable
ram_wdata  out  DATA_W  registered RAM write data
ram_rdata  in  DATA_W  RAM read data
cpu_starved  out  1  wait counter has reached MAX_WAIT (debug LED)

Behaviour:
- Reset (synchronous, active-high): ram_we=0, ram_addr=0, ram_wdata=0, tag pipe cleared, wait_cnt=0. All rvalid=0, all rdata=0, acks=0 while reset is high.
- Arbitration is combinational each cycle:
  - Only one req high: that requester is granted.
  - Both high, wait_cnt < MAX_WAIT: display granted.
  - Both high, wait_cnt >= MAX_WAIT: CPU granted.
  - Neither high: no grant.
- Exactly one ack per cycle at most; ack equals grant.
- wait_cnt, width clog2(MAX_WAIT+1):
  - Increments, saturating at MAX_WAIT, in any cycle cpu_req=1 and cpu_ack=0.
  - Clears to 0 on cpu_ack or when cpu_req=0.
  - cpu_starved = (wait_cnt == MAX_WAIT).
- Command stage: on the edge ending accept cycle N, ram_addr and ram_wdata load from the winner. ram_we = (winner is CPU and cpu_we). With no grant, ram_we=0 and ram_addr/ram_wdata hold their values.
- Tag pipe: RAM_LAT+1 stages, 2 bits each {is_read, owner}, shifted every cycle. A read accepted in cycle N raises the owner's rvalid in cycle N+1+RAM_LAT. The owner's rdata is captured from ram_rdata in that cycle and holds until the next rvalid of that owner.
- Writes produce no rvalid. CPU write data reaches RAM at the edge ending N+1.
- One access per cycle, fully pipelined; back-to-back accepts from either side are allowed. Read data returns in issue order.
- Read after write, same address, consecutive accepts: the read returns the new data (RAM is write-first; the arbiter adds no bypass).
- Requester rules: payload stable while req=1 and ack=0. Dropping req before ack is legal and cancels the request. wait_cnt clears in that case.
- Reset asserted mid-flight: in-flight reads are dropped with no rvalid. A pending write not yet registered is lost.
- Address wrap: addresses are used modulo 2^ADDR_W; no range checking (decode is done upstream).

Decomposition:
- Shared package screen_pkg:
  - SCREEN_ADDR_W=13, SCREEN_BASE=16'h4000.
  - Owner encoding OWN_CPU=1'b0, OWN_DISP=1'b1.
  - Tag struct {is_read, owner}.
- One natural sub-module, read_tag_pipe: parameterised shift register of tags that produces the rvalid strobes. Arbitration and command registers stay in the top module.

Test Plan:
- Idle reset: hold reset 3 cycles with both reqs high -> acks=0, rvalids=0, ram_we=0. First cycle after release: disp_ack=1.
- CPU write then read: CPU writes 0x1234 to 0x0005, then reads 0x0005, display idle, RAM_LAT=1 -> ram_we=1 with addr 5 one cycle after first ack. cpu_rvalid with 0x1234 two cycles after the read ack.
- Display streaming: disp_req constant, addresses 0..7 -> eight consecutive disp_acks. disp_rvalid in 8 consecutive cycles with data in order, first at ack+2.
- Starvation: MAX_WAIT=8, disp_req constant, CPU read pending -> cpu_ack in cycle 9 (after 8 denials). disp_ack=0 that cycle, cpu_starved=1 in cycle 9 only, wait_cnt returns to 0.
- Interleave with RAM_LAT=3: alternate CPU read 0x10 and display read 0x20, each preloaded -> rvalids 4 cycles after each ack. Each rdata is routed to the correct owner with no cross-talk.
- Reset mid-flight: assert reset the cycle after a CPU read ack -> no cpu_rvalid ever appears. The next read after reset returns correctly.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared definitions for the screen RAM arbiter: address geometry, owner
// encoding and the read tag carried down the return pipe.
package screen_pkg;
  localparam int          SCREEN_ADDR_W = 13;
  localparam logic [15:0] SCREEN_BASE   = 16'h4000;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_DISP = 1'b1;

  typedef struct packed {
    logic is_read;
    logic owner;
  } tag_t;
endpackage

// File: rtl/screen_ram_arbiter_read_tag_pipe.sv
// Shift register of read tags; the last stage lines up with valid RAM read
// data and becomes the per-owner rvalid strobe.
module read_tag_pipe
  import screen_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output logic cpu_rvalid,
  output logic disp_rvalid
);
  tag_t [STAGES-1:0] tag_pipe;

  always_ff @(posedge clk) begin
    if (reset) tag_pipe <= '0;
    else       tag_pipe <= {tag_pipe[STAGES-2:0], tag_in};
  end

  assign cpu_rvalid  = tag_pipe[STAGES-1].is_read && (tag_pipe[STAGES-1].owner == OWN_CPU);
  assign disp_rvalid = tag_pipe[STAGES-1].is_read && (tag_pipe[STAGES-1].owner == OWN_DISP);
endmodule

// File: rtl/screen_ram_arbiter.sv
// Single-port screen RAM shared by CPU and display: display has priority,
// a wait counter forces a CPU win after MAX_WAIT consecutive denials.
module screen_ram_arbiter
  import screen_pkg::*;
#(
  parameter int ADDR_W   = SCREEN_ADDR_W,
  parameter int DATA_W   = 16,
  parameter int RAM_LAT  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_starved
);
  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt;
  logic              grant_cpu, grant_disp;
  tag_t              tag_in;
  logic              cpu_rv_raw, disp_rv_raw;
  logic [DATA_W-1:0] cpu_hold, disp_hold;

  always_comb begin
    grant_cpu  = 1'b0;
    grant_disp = 1'b0;
    if (!reset) begin
      if (cpu_req && (!disp_req || wait_cnt >= WAIT_MAX)) grant_cpu  = 1'b1;
      else if (disp_req)                                  grant_disp = 1'b1;
    end
  end

  assign cpu_ack     = grant_cpu;
  assign disp_ack    = grant_disp;
  assign cpu_starved = (wait_cnt == WAIT_MAX);

  // Counts only uninterrupted denial; a withdrawn or accepted request restarts it.
  always_ff @(posedge clk) begin
    if (reset)                         wait_cnt <= '0;
    else if (cpu_req && !grant_cpu) begin
      if (wait_cnt != WAIT_MAX)        wait_cnt <= wait_cnt + 1'b1;
    end else                           wait_cnt <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= grant_cpu && cpu_we;
      if (grant_cpu) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
      end else if (grant_disp) begin
        ram_addr  <= disp_addr;
      end
    end
  end

  always_comb begin
    tag_in.is_read = (grant_cpu && !cpu_we) || grant_disp;
    tag_in.owner   = grant_disp ? OWN_DISP : OWN_CPU;
  end

  read_tag_pipe #(.STAGES(RAM_LAT + 1)) u_tag_pipe (
    .clk        (clk),
    .reset      (reset),
    .tag_in     (tag_in),
    .cpu_rvalid (cpu_rv_raw),
    .disp_rvalid(disp_rv_raw)
  );

  // Read data is passed straight through on the strobe cycle and held after.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_hold  <= '0;
      disp_hold <= '0;
    end else begin
      if (cpu_rv_raw)  cpu_hold  <= ram_rdata;
      if (disp_rv_raw) disp_hold <= ram_rdata;
    end
  end

  assign cpu_rvalid  = !reset && cpu_rv_raw;
  assign disp_rvalid = !reset && disp_rv_raw;
  assign cpu_rdata   = reset ? '0 : (cpu_rv_raw  ? ram_rdata : cpu_hold);
  assign disp_rdata  = reset ? '0 : (disp_rv_raw ? ram_rdata : disp_hold);
endmodule
